input_debouncer: RTL and testbench
==================================

// Module: input_debouncer
// PURPOSE
//   Synchronises a raw asynchronous input (push-button/switch) into clk and removes bounce.
//   A new level is accepted only after it has been stable for STABLE_CYCLES clocks.
//   Sits directly upstream of rising_edge_detector: out is a clean, glitch-free level.
//   The detector then turns that level into a one-cycle pulse.
// PARAMETERS
//   SYNC_STAGES    2      synchroniser flop count; must be >= 2
//   CNT_WIDTH      16     stability counter width; requires STABLE_CYCLES <= 2**CNT_WIDTH
//   STABLE_CYCLES  50000  consecutive stable synced cycles needed to commit; must be >= 1
//   INIT_LEVEL     1'b0   reset value of the synchroniser chain and of out
// PORTS
//   clk         in   1  clock, rising edge
//   rst         in   1  reset, asynchronous, active-low
//   in          in   1  raw asynchronous input
//   out         out  1  debounced level, registered
//   busy        out  1  1 while a candidate level is being qualified (CHECK_* state)
//   bounce_cnt  out  8  aborted-transition counter (present only with DEBOUNCE_BOUNCE_CNT_EN)
// BEHAVIOUR
//   Reset (rst=0, async):
//     - sync chain = INIT_LEVEL; state = STABLE_<INIT_LEVEL>; cnt = 0
//     - out = INIT_LEVEL; busy = 0; bounce_cnt = 0
//     - Takes effect immediately, including mid-qualification; any pending candidate is discarded.
//   Synchroniser: in -> SYNC_STAGES-deep flop chain; its last stage is s. FSM sees only s.
//   FSM states: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
//     STABLE_LO: s=1 -> CHECK_HI, cnt<=0; else stay.
//     CHECK_HI:  s=0 -> STABLE_LO, cnt<=0, abort.
//                s=1 and cnt==STABLE_CYCLES-1 -> STABLE_HI, out<=1, cnt<=0.
//                otherwise cnt<=cnt+1.
//     STABLE_HI / CHECK_LO: mirror image of the above (s=0 is the candidate; commit sets out<=0).
//   Counter:
//     - Counts only in CHECK_*; cleared on every state exit; never wraps.
//     - Comparison uses the full CNT_WIDTH.
//   Latency: let E0 be the first clk edge that samples the new stable in value.
//     - out updates at edge E(SYNC_STAGES+STABLE_CYCLES).
//     - Defaults: 50002 edges.
//   Glitch rejection:
//     - Any return of s to the committed level before commit aborts qualification.
//     - out does not change on an abort; qualification restarts from cnt=0 on the next deviation.
//   busy:
//     - Registered decode; 1 exactly while state is CHECK_HI or CHECK_LO.
//     - Falls on the same edge that out commits or the FSM aborts.
//   out changes at most once per qualification window. It never toggles twice within STABLE_CYCLES cycles.
// CONFIGURATION
//   DEBOUNCE_BOUNCE_CNT_EN defined:
//     - bounce_cnt port exists; it increments by 1 on every abort (CHECK_* -> STABLE_* without commit).
//     - Saturates at 8'hFF; cleared only by rst.
//   DEBOUNCE_BOUNCE_CNT_EN undefined:
//     - bounce_cnt port and its logic are absent.
//     - All other behaviour is identical.
// TESTING (bench uses SYNC_STAGES=2, STABLE_CYCLES=4, CNT_WIDTH=4, INIT_LEVEL=0)
//   1. Reset then idle: in=0 for 20 cycles -> out=0, busy=0, bounce_cnt=0 throughout.
//   2. Clean rise: in 0->1 held, sampled at E0.
//      -> busy=1 after E2; out=1 after E6; busy=0 after E6.
//   3. Bounce: in=1 for 3 cycles, 0 for 2, 1 held.
//      -> out stays 0 during the bounce; bounce_cnt=1; out=1 exactly 6 edges after final rise sampled.
//   4. Clean fall from out=1: in 1->0 held -> out=0 after E6; no out change before E6.
//   5. Reset mid-qualification: rst=0 asserted between edges while busy=1 with cnt=2.
//      -> out=0, busy=0, bounce_cnt=0 immediately, without waiting for clk.
//      After release, in=1 held -> full 6-edge latency again.
//   6. Saturation (DEBOUNCE_BOUNCE_CNT_EN): drive 300 one-cycle pulses spaced 8 cycles apart.
//      -> out never changes; bounce_cnt=8'hFF and holds there.

Source files
------------

// File: rtl/input_debouncer.sv
// input_debouncer: synchronises a raw input and commits a new level only after STABLE_CYCLES stable clocks.
// Optional abort counter on bounce_cnt when DEBOUNCE_BOUNCE_CNT_EN is defined.
module input_debouncer #(
  parameter int       SYNC_STAGES   = 2,
  parameter int       CNT_WIDTH     = 16,
  parameter int       STABLE_CYCLES = 50000,
  parameter bit       INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic busy
`ifdef DEBOUNCE_BOUNCE_CNT_EN
  ,
  output logic [7:0] bounce_cnt
`endif
);
  typedef enum logic [1:0] {STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam state_t INIT_STATE = INIT_LEVEL ? STABLE_HI : STABLE_LO;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   out_q, out_d, busy_q, busy_d, abort, s;
  assign s      = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], in};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    abort   = 1'b0;
    case (state_q)
      STABLE_LO: if (s) begin
        state_d = CHECK_HI;
        cnt_d   = '0;
      end
      CHECK_HI: if (!s) begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        abort   = 1'b1;
      end else if (cnt_q == LAST) begin
        state_d = STABLE_HI;
        out_d   = 1'b1;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      STABLE_HI: if (!s) begin
        state_d = CHECK_LO;
        cnt_d   = '0;
      end
      CHECK_LO: if (s) begin
        state_d = STABLE_HI;
        cnt_d   = '0;
        abort   = 1'b1;
      end else if (cnt_q == LAST) begin
        state_d = STABLE_LO;
        out_d   = 1'b0;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = INIT_STATE;
    endcase
    busy_d = (state_d == CHECK_HI) || (state_d == CHECK_LO);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
      state_q <= INIT_STATE;
      cnt_q   <= '0;
      out_q   <= INIT_LEVEL;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  assign out  = out_q;
  assign busy = busy_q;
`ifdef DEBOUNCE_BOUNCE_CNT_EN
  logic [7:0] bc_q, bc_d;
  // saturating so a long bounce storm cannot wrap back to a small count
  assign bc_d = (abort && bc_q != 8'hFF) ? bc_q + 8'd1 : bc_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) bc_q <= '0;
    else bc_q <= bc_d;
  assign bounce_cnt = bc_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif
endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: directed checks of latency, glitch rejection, async reset and abort saturation.
module tb_input_debouncer;
  logic clk, rst, in, out, busy;
`ifdef DEBOUNCE_BOUNCE_CNT_EN
  logic [7:0] bounce_cnt;
`endif
  int checks = 0;
  int errors = 0;

  input_debouncer #(
    .SYNC_STAGES(2), .CNT_WIDTH(4), .STABLE_CYCLES(4), .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .busy(busy)
`ifdef DEBOUNCE_BOUNCE_CNT_EN
    , .bounce_cnt(bounce_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bc(input string tag, input logic [7:0] exp);
`ifdef DEBOUNCE_BOUNCE_CNT_EN
    check(tag, {24'd0, bounce_cnt}, {24'd0, exp});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // drive a new level just after an edge; the next edge is E0, out must commit exactly at E6
  task automatic qualify(input logic lvl, input string tag);
    in = lvl;
    for (int k = 0; k <= 6; k++) begin
      step();
      check($sformatf("%s_out_E%0d", tag, k), {31'd0, out}, {31'd0, (k >= 6) ? lvl : ~lvl});
      check($sformatf("%s_busy_E%0d", tag, k), {31'd0, busy}, {31'd0, (k >= 2 && k < 6)});
    end
  endtask

  initial begin
    rst = 1'b0;
    in  = 1'b0;
    #2;
    check("rst_out", {31'd0, out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check_bc("rst_bc", 8'h00);
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_out", {31'd0, out}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check_bc("idle_bc", 8'h00);
    end
    qualify(1'b1, "rise");
    qualify(1'b0, "fall");
    // bounce: 1 for 3 cycles, 0 for 2, then 1 held
    in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bounce_hi_out", {31'd0, out}, 32'd0);
    end
    in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("bounce_lo_out", {31'd0, out}, 32'd0);
    end
    qualify(1'b1, "bounce_final");
    check_bc("bounce_bc", 8'h01);
    // reset mid-qualification of a fall (busy=1, cnt=2 after E4)
    in = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    check("pre_rst_out", {31'd0, out}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_out", {31'd0, out}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check_bc("async_rst_bc", 8'h00);
    step();
    rst = 1'b1;
    step();
    step();
    check("post_rst_out", {31'd0, out}, 32'd0);
    qualify(1'b1, "post_rst_rise");
    qualify(1'b0, "pre_sat_fall");
    // 300 one-cycle pulses, each aborting once
    for (int p = 0; p < 300; p++) begin
      in = 1'b1;
      step();
      in = 1'b0;
      for (int i = 0; i < 7; i++) begin
        step();
        check("sat_out", {31'd0, out}, 32'd0);
      end
      if (p == 0) check_bc("sat_bc_first", 8'h01);
      if (p == 253) check_bc("sat_bc_254", 8'hFE);
      if (p == 254) check_bc("sat_bc_255", 8'hFF);
    end
    check_bc("sat_bc_end", 8'hFF);
    for (int i = 0; i < 10; i++) step();
    check_bc("sat_bc_hold", 8'hFF);
    check("final_out", {31'd0, out}, 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
